gate_selftest_ctrl: RTL and testbench

GATE_SELFTEST_CTRL -- requirements
Module: gate_selftest_ctrl

---
 rtl/gate_selftest_pkg.sv | 35 +++
 rtl/gate_model.sv | 21 ++
 rtl/gate_selftest_ctrl.sv | 132 +++++++++++++
 tb/tb_gate_selftest_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_selftest_pkg.sv
// Shared types and constants for the gate-unit self-test controller.
// obs bit order is {and, or, not, nand, nor, xor, xnor}, MSB first.
package gate_selftest_pkg;

   localparam int unsigned NUM_VEC = 4;
   localparam int unsigned VEC_W   = 2;
   localparam int unsigned OBS_W   = 7;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned ERR_W   = 3;

   localparam int unsigned OBS_AND  = 6;
   localparam int unsigned OBS_OR   = 5;
   localparam int unsigned OBS_NOT  = 4;
   localparam int unsigned OBS_NAND = 3;
   localparam int unsigned OBS_NOR  = 2;
   localparam int unsigned OBS_XOR  = 1;
   localparam int unsigned OBS_XNOR = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Number of failing vectors in a per-vector mismatch mask.
   function automatic logic [ERR_W-1:0] popcount_mask(input logic [NUM_VEC-1:0] m);
      logic [ERR_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_VEC; i++) begin
         n = n + ERR_W'(m[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/gate_model.sv
// Reference response of a correct basic gate unit for operands a and b.
module gate_model
   import gate_selftest_pkg::*;
(
   input  logic             a,
   input  logic             b,
   output logic [OBS_W-1:0] expected
);

   always_comb begin
      expected           = '0;
      expected[OBS_AND]  = a & b;
      expected[OBS_OR]   = a | b;
      expected[OBS_NOT]  = ~a;
      expected[OBS_NAND] = ~(a & b);
      expected[OBS_NOR]  = ~(a | b);
      expected[OBS_XOR]  = a ^ b;
      expected[OBS_XNOR] = ~(a ^ b);
   end

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Sweeps the four operand pairs through a gate unit, holds each for DWELL
// cycles, compares the observed outputs and reports a registered verdict.
module gate_selftest_ctrl
   import gate_selftest_pkg::*;
#(
   parameter int unsigned DWELL = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [OBS_W-1:0]   obs,
   output logic               in1,
   output logic               in2,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [NUM_VEC-1:0] fail_mask,
   output logic [ERR_W-1:0]   err_count
);

   state_e             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               in1_q, in1_d, in2_q, in2_d;
   logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [NUM_VEC-1:0] mask_q, mask_d;
   logic [ERR_W-1:0]   err_q, err_d;

   logic [OBS_W-1:0]   exp_obs;
   logic [NUM_VEC-1:0] mask_upd;
   logic [VEC_W-1:0]   vec_nxt;
   logic               last_dwell, last_vec;

   gate_model u_gate_model (
      .a        (vec_q[1]),
      .b        (vec_q[0]),
      .expected (exp_obs)
   );

   assign last_dwell = (cnt_q == CNT_W'(DWELL - 1));
   assign last_vec   = (vec_q == VEC_W'(NUM_VEC - 1));
   assign vec_nxt    = vec_q + VEC_W'(1);
   assign mask_upd   = mask_q | (NUM_VEC'(obs != exp_obs) << vec_q);

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      mask_d  = mask_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_APPLY;
               vec_d   = '0;
               cnt_d   = '0;
               in1_d   = 1'b0;
               in2_d   = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               mask_d  = '0;
               err_d   = '0;
            end
         end
         ST_APPLY: begin
            if (last_dwell) begin
               cnt_d  = '0;
               mask_d = mask_upd;
               if (last_vec) begin
                  state_d = ST_DONE;
                  vec_d   = '0;
                  in1_d   = 1'b0;
                  in2_d   = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (mask_upd == '0);
                  err_d   = popcount_mask(mask_upd);
               end else begin
                  vec_d = vec_nxt;
                  in1_d = vec_nxt[1];
                  in2_d = vec_nxt[0];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         in1_q   <= 1'b0;
         in2_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mask_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
      end
   end

   assign in1       = in1_q;
   assign in2       = in2_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = mask_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: two instances (DWELL 10 and 2) driven by a
// fault-injectable gate unit, checked each cycle against a time-based model.
module tb_gate_selftest_ctrl;
   import gate_selftest_pkg::*;

   localparam int unsigned D0 = 10;
   localparam int unsigned D1 = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   logic [6:0] obs0, obs1;
   logic in1_0, in2_0, busy0, done0, pass0;
   logic in1_1, in2_1, busy1, done1, pass1;
   logic [3:0] fm0, fm1;
   logic [2:0] ec0, ec1;

   logic [6:0] keep0 = 7'h7f, keep1 = 7'h7f;
   logic [6:0] fx0 [4] = '{7'h0, 7'h0, 7'h0, 7'h0};
   logic [6:0] fx1 [4] = '{7'h0, 7'h0, 7'h0, 7'h0};

   int  nvec = 0;
   int  nerr = 0;
   bit  checking = 1'b0;

   int         dw    [2] = '{D0, D1};
   int         mk    [2] = '{0, 0};
   bit         mbusy [2] = '{1'b0, 1'b0};
   bit         mdone [2] = '{1'b0, 1'b0};
   bit         mpass [2] = '{1'b0, 1'b0};
   logic [3:0] mmask [2] = '{4'h0, 4'h0};

   always #5 clk = ~clk;

   // Truth table of a correct gate unit, indexed by {A,B}.
   function automatic logic [6:0] tt(input int v);
      case (v)
         0:       return 7'b0011101;
         1:       return 7'b0111010;
         2:       return 7'b0101010;
         default: return 7'b1100001;
      endcase
   endfunction

   function automatic logic [6:0] drv(input int i, input int v);
      logic [1:0] idx;
      idx = v[1:0];
      if (i == 0) return (tt(v) & keep0) ^ fx0[idx];
      return (tt(v) & keep1) ^ fx1[idx];
   endfunction

   assign obs0 = (tt(int'({in1_0, in2_0})) & keep0) ^ fx0[{in1_0, in2_0}];
   assign obs1 = (tt(int'({in1_1, in2_1})) & keep1) ^ fx1[{in1_1, in2_1}];

   gate_selftest_ctrl #(.DWELL(D0)) u0 (
      .clk(clk), .rst(rst), .start(start0), .obs(obs0),
      .in1(in1_0), .in2(in2_0), .busy(busy0), .done(done0), .pass(pass0),
      .fail_mask(fm0), .err_count(ec0)
   );

   gate_selftest_ctrl #(.DWELL(D1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .obs(obs1),
      .in1(in1_1), .in2(in2_1), .busy(busy1), .done(done1), .pass(pass1),
      .fail_mask(fm1), .err_count(ec1)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_u0"}, 32'({in1_0, in2_0, busy0, done0, pass0, fm0, ec0}), 32'd0);
      chk({tag, "_u1"}, 32'({in1_1, in2_1, busy1, done1, pass1, fm1, ec1}), 32'd0);
   endtask

   task automatic pulse(input bit s0, input bit s1);
      start0 = s0;
      start1 = s1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Model: a sweep is just an edge counter since the accepting edge.
   always @(posedge clk or posedge rst) begin : model
      int k; int v; bit b; bit d; bit p; bit s; logic [3:0] m;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            k = 0; b = 1'b0; d = 1'b0; p = 1'b0; m = 4'h0;
         end else begin
            k = mk[i]; b = mbusy[i]; d = mdone[i]; p = mpass[i]; m = mmask[i];
            s = (i == 0) ? start0 : start1;
            if (!b) begin
               if (s) begin
                  b = 1'b1; k = 0; m = 4'h0; d = 1'b0; p = 1'b0;
               end
            end else begin
               k = k + 1;
               if (k % dw[i] == 0) begin
                  v = k / dw[i] - 1;
                  if (drv(i, v) != tt(v)) m[v] = 1'b1;
               end
               if (k == 4 * dw[i]) begin
                  b = 1'b0; d = 1'b1; p = (m == 4'h0);
               end
            end
         end
         mk[i] <= k; mbusy[i] <= b; mdone[i] <= d; mpass[i] <= p; mmask[i] <= m;
      end
   end

   always @(negedge clk) begin : compare
      logic [8:0] e; logic [8:0] g; int v;
      if (checking) begin
         for (int i = 0; i < 2; i++) begin
            v = mbusy[i] ? mk[i] / dw[i] : 0;
            e = {mbusy[i] ? v[1] : 1'b0, mbusy[i] ? v[0] : 1'b0,
                 mbusy[i], mdone[i], mpass[i], mmask[i]};
            g = (i == 0) ? {in1_0, in2_0, busy0, done0, pass0, fm0}
                         : {in1_1, in2_1, busy1, done1, pass1, fm1};
            chk($sformatf("u%0d_cycle", i), 32'(g), 32'(e));
            if (!mbusy[i])
               chk($sformatf("u%0d_err_count", i), 32'((i == 0) ? ec0 : ec1),
                   32'($countones(mmask[i])));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] jv;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      checking = 1'b1;

      // Clean sweep on both; DWELL=2 instance sequence pinned by hand.
      pulse(1'b1, 1'b1);
      for (int j = 0; j < 8; j++) begin
         jv = 2'(j / 2);
         chk("u1_seq", 32'({in1_1, in2_1}), 32'(jv));
         chk("u1_done_early", 32'(done1), 32'd0);
         @(negedge clk);
      end
      chk("u1_done_edge8", 32'({done1, pass1, fm1, ec1}), 32'b1_1_0000_000);
      repeat (31) @(negedge clk);
      chk("u0_done_edge39", 32'(done0), 32'd0);
      @(negedge clk);
      chk("u0_clean_edge40", 32'({done0, pass0, fm0, ec0}), 32'b1_1_0000_000);

      // xor output stuck at 0, with ignored starts at cycles 5 and 25.
      keep0 = 7'b1111101;
      pulse(1'b1, 1'b0);
      repeat (4) @(negedge clk);
      pulse(1'b1, 1'b0);
      repeat (19) @(negedge clk);
      pulse(1'b1, 1'b0);
      repeat (14) @(negedge clk);
      chk("u0_xor_edge39", 32'(done0), 32'd0);
      @(negedge clk);
      chk("u0_xor_edge40", 32'({done0, pass0, fm0, ec0}), 32'b1_0_0110_010);

      // Restart from a failed DONE with a healthy unit.
      keep0 = 7'h7f;
      pulse(1'b1, 1'b0);
      chk("u0_restart_clear", 32'({busy0, done0, pass0, fm0, ec0}), 32'b1_0_0_0000_000);
      repeat (40) @(negedge clk);
      chk("u0_restart_pass", 32'({done0, pass0, fm0}), 32'b1_1_0000);

      // Asynchronous reset mid-sweep, then a full clean sweep.
      pulse(1'b1, 1'b0);
      repeat (15) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      pulse(1'b1, 1'b0);
      repeat (39) @(negedge clk);
      chk("u0_post_rst_edge39", 32'(done0), 32'd0);
      @(negedge clk);
      chk("u0_post_rst_edge40", 32'({done0, pass0, fm0}), 32'b1_1_0000);

      // Randomized sweeps with random faults, stray starts and resets.
      for (int it = 0; it < 40; it++) begin
         keep0 = ($urandom_range(1) == 0) ? 7'h7f : 7'($urandom);
         keep1 = ($urandom_range(1) == 0) ? 7'h7f : 7'($urandom);
         for (int v = 0; v < 4; v++) begin
            fx0[v] = ($urandom_range(2) == 0) ? 7'($urandom) : 7'h0;
            fx1[v] = ($urandom_range(2) == 0) ? 7'($urandom) : 7'h0;
         end
         pulse(1'b1, 1'($urandom_range(1)));
         for (int c = 0; c < 45; c++) begin
            start0 = ($urandom_range(7) == 0);
            start1 = ($urandom_range(5) == 0);
            if ($urandom_range(149) == 0) begin
               #2 rst = 1'b1;
               #1 chk_zero("rand_rst");
               @(negedge clk);
               rst = 1'b0;
            end else begin
               @(negedge clk);
            end
         end
         start0 = 1'b0;
         start1 = 1'b0;
         @(negedge clk);
      end

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
